// File: rtl/reg_file_rename_pkg.sv
// Shared definitions for the renamed architectural register file.
// Default widths here size the top; the typedefs describe the default configuration.
package reg_file_rename_pkg;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_REG_IDX_W = 5;
    localparam int unsigned DEF_ROB_IDX_W = 4;

    localparam int unsigned REG_COUNT = 2 ** DEF_REG_IDX_W;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [DEF_DATA_W-1:0]    data_type_t;
    typedef logic [DEF_REG_IDX_W-1:0] reg_index_type_t;
    typedef logic [DEF_ROB_IDX_W-1:0] rob_index_type_t;

endpackage

// File: rtl/reg_file_rename_reg_read_port.sv
// One operand read port: x0 forcing plus same-cycle bypass of a matching ROB commit.
// Purely combinational; the top hands in the state slice for the addressed register.
module reg_read_port
    import reg_file_rename_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned REG_IDX_W = DEF_REG_IDX_W,
    parameter int unsigned ROB_IDX_W = DEF_ROB_IDX_W
) (
    input  logic [REG_IDX_W-1:0] rs_index,
    input  logic [DATA_W-1:0]    st_val,
    input  logic                 st_busy,
    input  logic [ROB_IDX_W-1:0] st_tag,
    input  logic                 rob_commit,
    input  logic [ROB_IDX_W-1:0] rob_commit_rob_index,
    input  logic [REG_IDX_W-1:0] rob_commit_rd,
    input  logic [DATA_W-1:0]    rob_commit_val,
    output logic                 rs_busy,
    output logic [ROB_IDX_W-1:0] rs_tag,
    output logic [DATA_W-1:0]    rs_val
);

    logic is_x0;
    logic bypass_hit;

    always_comb begin
        is_x0      = (rs_index == '0);
        // Only the exact producer's commit may resolve a busy operand.
        bypass_hit = rob_commit && (rob_commit_rd == rs_index) && !is_x0 && st_busy &&
                     (st_tag == rob_commit_rob_index);
    end

    always_comb begin
        rs_busy = st_busy;
        rs_tag  = st_tag;
        rs_val  = st_val;
        if (is_x0) begin
            rs_busy = FALSE;
            rs_tag  = '0;
            rs_val  = '0;
        end else if (bypass_hit) begin
            rs_busy = FALSE;
            rs_val  = rob_commit_val;
        end
    end

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags, fed by ROB commit/flush
// and queried/renamed by the decoder. x0 is hardwired to zero and never renamed.
module reg_file_rename
    import reg_file_rename_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned REG_IDX_W = DEF_REG_IDX_W,
    parameter int unsigned ROB_IDX_W = DEF_ROB_IDX_W
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 rob_commit,
    input  logic [ROB_IDX_W-1:0] rob_commit_rob_index,
    input  logic [REG_IDX_W-1:0] rob_commit_rd,
    input  logic [DATA_W-1:0]    rob_commit_val,
    input  logic                 dc_rename_valid,
    input  logic [REG_IDX_W-1:0] dc_rename_rd,
    input  logic [ROB_IDX_W-1:0] dc_rename_rob_index,
    input  logic [REG_IDX_W-1:0] dc_rs1_index,
    input  logic [REG_IDX_W-1:0] dc_rs2_index,
    output logic                 rs1_busy,
    output logic [ROB_IDX_W-1:0] rs1_tag,
    output logic [DATA_W-1:0]    rs1_val,
    output logic                 rs2_busy,
    output logic [ROB_IDX_W-1:0] rs2_tag,
    output logic [DATA_W-1:0]    rs2_val
);

    localparam int unsigned NumRegs = 2 ** REG_IDX_W;

    logic [DATA_W-1:0]    val_q  [NumRegs];
    logic [DATA_W-1:0]    val_d  [NumRegs];
    logic [ROB_IDX_W-1:0] tag_q  [NumRegs];
    logic [ROB_IDX_W-1:0] tag_d  [NumRegs];
    logic [NumRegs-1:0]   busy_q;
    logic [NumRegs-1:0]   busy_d;

    logic commit_en;
    logic commit_clears;
    logic rename_en;

    always_comb begin
        commit_en     = rob_commit && (rob_commit_rd != '0);
        // A mismatched tag means a younger rename owns the register; keep it busy.
        commit_clears = commit_en && (tag_q[rob_commit_rd] == rob_commit_rob_index);
        rename_en     = rdy_in && !flush_in && dc_rename_valid && (dc_rename_rd != '0);
    end

    // Priority: commit, then flush clears all busy, then rename wins over both.
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;

        if (commit_en) begin
            val_d[rob_commit_rd] = rob_commit_val;
            if (commit_clears) begin
                busy_d[rob_commit_rd] = FALSE;
            end
        end

        if (flush_in) begin
            busy_d = '0;
        end

        if (rename_en) begin
            busy_d[dc_rename_rd] = TRUE;
            tag_d[dc_rename_rd]  = dc_rename_rob_index;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < int'(NumRegs); i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < int'(NumRegs); i++) begin
                val_q[i] <= val_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

    reg_read_port #(
        .DATA_W    (DATA_W),
        .REG_IDX_W (REG_IDX_W),
        .ROB_IDX_W (ROB_IDX_W)
    ) u_rs1_port (
        .rs_index             (dc_rs1_index),
        .st_val               (val_q[dc_rs1_index]),
        .st_busy              (busy_q[dc_rs1_index]),
        .st_tag               (tag_q[dc_rs1_index]),
        .rob_commit           (rob_commit),
        .rob_commit_rob_index (rob_commit_rob_index),
        .rob_commit_rd        (rob_commit_rd),
        .rob_commit_val       (rob_commit_val),
        .rs_busy              (rs1_busy),
        .rs_tag               (rs1_tag),
        .rs_val               (rs1_val)
    );

    reg_read_port #(
        .DATA_W    (DATA_W),
        .REG_IDX_W (REG_IDX_W),
        .ROB_IDX_W (ROB_IDX_W)
    ) u_rs2_port (
        .rs_index             (dc_rs2_index),
        .st_val               (val_q[dc_rs2_index]),
        .st_busy              (busy_q[dc_rs2_index]),
        .st_tag               (tag_q[dc_rs2_index]),
        .rob_commit           (rob_commit),
        .rob_commit_rob_index (rob_commit_rob_index),
        .rob_commit_rd        (rob_commit_rd),
        .rob_commit_val       (rob_commit_val),
        .rs_busy              (rs2_busy),
        .rs_tag               (rs2_tag),
        .rs_val               (rs2_val)
    );

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed bench for reg_file_rename: rename, commit bypass, tag mismatch, flush,
// x0 and stall handling, and asynchronous reset.
module tb_reg_file_rename;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        rob_commit;
    logic [3:0]  rob_commit_rob_index;
    logic [4:0]  rob_commit_rd;
    logic [31:0] rob_commit_val;
    logic        dc_rename_valid;
    logic [4:0]  dc_rename_rd;
    logic [3:0]  dc_rename_rob_index;
    logic [4:0]  dc_rs1_index;
    logic [4:0]  dc_rs2_index;
    logic        rs1_busy;
    logic [3:0]  rs1_tag;
    logic [31:0] rs1_val;
    logic        rs2_busy;
    logic [3:0]  rs2_tag;
    logic [31:0] rs2_val;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk_in = ~clk_in;

    reg_file_rename dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .rdy_in               (rdy_in),
        .flush_in             (flush_in),
        .rob_commit           (rob_commit),
        .rob_commit_rob_index (rob_commit_rob_index),
        .rob_commit_rd        (rob_commit_rd),
        .rob_commit_val       (rob_commit_val),
        .dc_rename_valid      (dc_rename_valid),
        .dc_rename_rd         (dc_rename_rd),
        .dc_rename_rob_index  (dc_rename_rob_index),
        .dc_rs1_index         (dc_rs1_index),
        .dc_rs2_index         (dc_rs2_index),
        .rs1_busy             (rs1_busy),
        .rs1_tag              (rs1_tag),
        .rs1_val              (rs1_val),
        .rs2_busy             (rs2_busy),
        .rs2_tag              (rs2_tag),
        .rs2_val              (rs2_val)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        flush_in        = 1'b0;
        rob_commit      = 1'b0;
        rob_commit_rob_index = '0;
        rob_commit_rd   = '0;
        rob_commit_val  = '0;
        dc_rename_valid = 1'b0;
        dc_rename_rd    = '0;
        dc_rename_rob_index = '0;
    endtask

    // Advance one clock edge, then release the one-cycle request inputs.
    task automatic step();
        @(posedge clk_in);
        #1;
        clear_inputs();
        #1;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [3:0] idx);
        dc_rename_valid     = 1'b1;
        dc_rename_rd        = rd;
        dc_rename_rob_index = idx;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [3:0] idx, input logic [31:0] v);
        rob_commit           = 1'b1;
        rob_commit_rd        = rd;
        rob_commit_rob_index = idx;
        rob_commit_val       = v;
    endtask

    task automatic read_regs(input logic [4:0] r1, input logic [4:0] r2);
        dc_rs1_index = r1;
        dc_rs2_index = r2;
        #1;
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        dc_rs1_index = 5'd5;
        dc_rs2_index = 5'd0;
        clear_inputs();
        #2;
        check_eq("reset_x5_busy", 32'(rs1_busy), 32'd0);
        check_eq("reset_x5_val", rs1_val, 32'd0);
        #10;
        rst_in = 1'b0;
        @(negedge clk_in);

        // Commit to a non-busy register: value lands, busy untouched.
        do_commit(5'd5, 4'd3, 32'h1234);
        step();
        read_regs(5'd5, 5'd0);
        check_eq("commit_idle_val", rs1_val, 32'h1234);
        check_eq("commit_idle_busy", 32'(rs1_busy), 32'd0);

        // Rename then commit with same-cycle bypass.
        do_rename(5'd7, 4'd2);
        step();
        read_regs(5'd7, 5'd7);
        check_eq("rename_busy", 32'(rs1_busy), 32'd1);
        check_eq("rename_tag", 32'(rs1_tag), 32'd2);
        do_commit(5'd7, 4'd2, 32'hDEAD);
        #1;
        check_eq("bypass_busy", 32'(rs1_busy), 32'd0);
        check_eq("bypass_val", rs1_val, 32'hDEAD);
        check_eq("bypass_rs2_val", rs2_val, 32'hDEAD);
        step();
        check_eq("post_commit_busy", 32'(rs1_busy), 32'd0);
        check_eq("post_commit_val", rs1_val, 32'hDEAD);

        // Older commit against a younger rename keeps busy and tag.
        do_rename(5'd7, 4'd2);
        step();
        do_rename(5'd7, 4'd4);
        step();
        do_commit(5'd7, 4'd2, 32'h11);
        #1;
        check_eq("stale_bypass_busy", 32'(rs2_busy), 32'd1);
        step();
        check_eq("stale_busy", 32'(rs2_busy), 32'd1);
        check_eq("stale_tag", 32'(rs2_tag), 32'd4);
        check_eq("stale_val", rs2_val, 32'h11);
        do_commit(5'd7, 4'd4, 32'h22);
        step();
        check_eq("young_commit_busy", 32'(rs2_busy), 32'd0);
        check_eq("young_commit_val", rs2_val, 32'h22);

        // Commit and rename to the same rd in one cycle: rename owns the register.
        do_rename(5'd9, 4'd1);
        step();
        do_commit(5'd9, 4'd1, 32'h55);
        do_rename(5'd9, 4'd6);
        step();
        read_regs(5'd9, 5'd0);
        check_eq("same_cyc_busy", 32'(rs1_busy), 32'd1);
        check_eq("same_cyc_tag", 32'(rs1_tag), 32'd6);
        check_eq("same_cyc_val", rs1_val, 32'h55);

        // Flush with a concurrent commit and a dropped rename.
        do_commit(5'd4, 4'd0, 32'hAB);
        step();
        do_rename(5'd3, 4'd5);
        step();
        do_rename(5'd4, 4'd7);
        step();
        do_rename(5'd8, 4'd8);
        step();
        read_regs(5'd8, 5'd4);
        check_eq("pre_flush_x8_busy", 32'(rs1_busy), 32'd1);
        flush_in = 1'b1;
        do_commit(5'd3, 4'd5, 32'h77);
        do_rename(5'd10, 4'd9);
        step();
        check_eq("flush_x8_busy", 32'(rs1_busy), 32'd0);
        check_eq("flush_x8_val", rs1_val, 32'd0);
        check_eq("flush_x4_busy", 32'(rs2_busy), 32'd0);
        check_eq("flush_x4_val", rs2_val, 32'hAB);
        read_regs(5'd3, 5'd9);
        check_eq("flush_x3_busy", 32'(rs1_busy), 32'd0);
        check_eq("flush_x3_val", rs1_val, 32'h77);
        check_eq("flush_x9_busy", 32'(rs2_busy), 32'd0);
        read_regs(5'd10, 5'd0);
        check_eq("flush_drop_rename", 32'(rs1_busy), 32'd0);

        // x0 ignores rename and commit.
        do_rename(5'd0, 4'd5);
        do_commit(5'd0, 4'd5, 32'hFFFF);
        read_regs(5'd0, 5'd0);
        check_eq("x0_bypass_val", rs1_val, 32'd0);
        step();
        check_eq("x0_busy", 32'(rs1_busy), 32'd0);
        check_eq("x0_val", rs1_val, 32'd0);
        check_eq("x0_tag", 32'(rs1_tag), 32'd0);

        // Stall: rename suppressed, commit still applied.
        rdy_in = 1'b0;
        do_rename(5'd10, 4'd1);
        do_commit(5'd11, 4'd0, 32'h99);
        step();
        rdy_in = 1'b1;
        read_regs(5'd10, 5'd11);
        check_eq("stall_rename_busy", 32'(rs1_busy), 32'd0);
        check_eq("stall_commit_val", rs2_val, 32'h99);

        // Asynchronous reset between clock edges.
        do_rename(5'd12, 4'd3);
        step();
        read_regs(5'd12, 5'd7);
        check_eq("pre_reset_busy", 32'(rs1_busy), 32'd1);
        rst_in = 1'b1;
        #1;
        check_eq("async_reset_busy", 32'(rs1_busy), 32'd0);
        check_eq("async_reset_tag", 32'(rs1_tag), 32'd0);
        check_eq("async_reset_val", rs2_val, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags, sitting directly downstream of the reorder buffer.
- Consumes the ROB commit stream (value, rd, ROB index) and the ROB flush pulse.
- Gives the decoder operand values, or the in-flight ROB tag that will produce them, and records the decoder's destination renames.
- 32 x 32-bit registers; x0 hardwired to zero.

Parameters:
- DATA_W, 32, register/data width
- REG_IDX_W, 5, register index width (2^REG_IDX_W registers)
- ROB_IDX_W, 4, ROB index (tag) width; must match ROB sizing

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-high reset
- rdy_in  in  1  global ready; low stalls rename only
- flush_in  in  1  misprediction flush pulse from ROB
- rob_commit  in  1  commit valid
- rob_commit_rob_index  in  ROB_IDX_W  ROB entry being retired
- rob_commit_rd  in  REG_IDX_W  destination register of retired entry
- rob_commit_val  in  DATA_W  retired result
- dc_rename_valid  in  1  decoder issues an instruction that writes rd
- dc_rename_rd  in  REG_IDX_W  destination register being renamed
- dc_rename_rob_index  in  ROB_IDX_W  ROB entry allocated to it
- dc_rs1_index  in  REG_IDX_W  source 1 lookup
- dc_rs2_index  in  REG_IDX_W  source 2 lookup
- rs1_busy  out  1  rs1 awaits an in-flight result
- rs1_tag  out  ROB_IDX_W  producing ROB index, valid when rs1_busy
- rs1_val  out  DATA_W  rs1 value, valid when !rs1_busy
- rs2_busy, rs2_tag, rs2_val  out  1/ROB_IDX_W/DATA_W  same for rs2

Behaviour:
- State: val[0..31], busy[0..31], tag[0..31].
- Reset (async, rst_in high):
  - all val=0, busy=0, tag=0.
  - Read outputs are combinational, so they reflect the cleared state immediately.
- Reads are combinational from current state, with commit bypass:
  - If rob_commit && rob_commit_rd==rsN && rsN!=0 && busy[rsN] && tag[rsN]==rob_commit_rob_index, then rsN_busy=0 and rsN_val=rob_commit_val.
  - Reads do not bypass this cycle's rename; the decoder handles same-instruction rd==rs itself.
- x0: reads always busy=0, val=0, tag=0. Commit and rename to rd=0 are ignored.
- Commit (posedge; applied regardless of rdy_in and regardless of flush_in):
  - If rob_commit && rd!=0, then val[rd] <= rob_commit_val.
  - busy[rd] <= 0 only if tag[rd]==rob_commit_rob_index, and no rename to the same rd wins this cycle.
  - A tag mismatch means a younger writer still owns the register: value is updated, busy and tag are kept.
- Rename (posedge; only when rdy_in && !flush_in && dc_rename_valid && rd!=0): busy[rd] <= 1, tag[rd] <= dc_rename_rob_index.
- Same-cycle commit and rename to the same rd: value written from the commit; busy=1 and tag=new index from the rename.
- Flush (posedge, flush_in high): all busy <= 0 and tags are retained but meaningless; values retained.
  - The commit presented in the same cycle is still applied, because the ROB emits the mispredicting branch's commit together with its flush.
- rdy_in low: rename suppressed; commit and flush still applied (the ROB holds commit/flush registers across a stall).
- Latency: a commit is visible on reads the same cycle via bypass and from state the next cycle. A rename is visible the next cycle.
- Tag wrap-around: tags are ROB indices reused modulo 2^ROB_IDX_W. The exact-match rule is correct because the ROB never holds two live entries with the same index.

Decomposition:
- Shared def package: DATA_TYPE, REG_INDEX_TYPE, ROB_INDEX_TYPE, TRUE/FALSE, REG_COUNT.
- One sub-module, reg_read_port, instantiated twice: per-port combinational x0 handling plus commit bypass, given state slices and commit inputs.

Test Plan:
- Reset → read x5: busy=0, val=0. Commit rd=5, idx=3, val=0x1234 while busy[5]=0 → val[5]=0x1234, busy stays 0.
- Rename x7→idx 2, next cycle read x7 → busy=1, tag=2. Commit x7/idx 2/0xDEAD → same-cycle read busy=0, val=0xDEAD; next cycle same from state.
- Rename x7→2, then x7→4, then commit x7/idx 2/0x11 → val[7]=0x11, busy=1, tag=4 kept. Commit idx 4/0x22 → busy=0, val=0x22.
- Same cycle: commit x9/idx 1/0x55 and rename x9→6 → next cycle busy=1, tag=6, val[9]=0x55.
- Rename x3,x4,x8; then flush_in with commit x3/idx of x3/0x77 → all busy=0, val[3]=0x77, x4/x8 keep old values. A rename asserted with the flush is dropped.
- rd=0: rename x0→5 and commit x0/0xFFFF → read x0 busy=0, val=0. rdy_in low with rename x10→1 → busy[10] stays 0.
- Async reset asserted mid-run between clock edges → outputs clear immediately, without waiting for a clock edge.
